// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared definitions for the keypad entry controller: FSM encodings, digit limits
// and the four-digit entry register layout.
package keypad_entry_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE = 3'd1;
  localparam logic [2:0] ST_HELD     = 3'd2;
  localparam logic [2:0] ST_RELEASE  = 3'd3;
  localparam logic [2:0] ST_LOCKED   = 3'd4;

  localparam logic [3:0] MAX_SEC_TENS = 4'd5;
  localparam logic [3:0] MAX_BCD      = 4'd9;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } digits_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= MAX_BCD;
  endfunction

  // New digit enters at sec_ones; the old min_tens falls off the top.
  function automatic digits_t shift_in(input digits_t d, input logic [3:0] digit);
    digits_t r;
    r.min_tens = d.min_ones;
    r.min_ones = d.sec_tens;
    r.sec_tens = d.sec_ones;
    r.sec_ones = digit;
    return r;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_key_debounce.sv
// Debounce counter plus captured key code; reports whether the current key matches
// the captured one and whether the stable-cycle count has reached its terminal value.
module key_debounce
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       count,
  input  logic       capture,
  input  logic [3:0] code,
  input  logic       key_valid,
  output logic       stable,
  output logic       terminal
);

  localparam logic [7:0] TC = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] cnt;
  logic [3:0] code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 8'd0;
      code_q <= 4'd0;
    end else begin
      if (clear)
        cnt <= 8'd0;
      else if (count)
        cnt <= cnt + 8'd1;
      if (capture)
        code_q <= code;
    end
  end

  assign stable   = key_valid && (code == code_q);
  assign terminal = (cnt == TC);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad time-entry controller: debounces digit keys, shifts accepted digits into
// an MM:SS register, and hands the entry to the downstream timer on start.
module keypad_entry_ctrl
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [3:0] bcd,
  input  logic       clear_key,
  input  logic       start_key,
  input  logic       timer_busy,
  output logic       enc_nenable,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       load,
  output logic       entry_err
);

  // state    | meaning
  // IDLE     | waiting for a key or a start edge
  // DEBOUNCE | key seen, counting stable cycles
  // HELD     | digit accepted, waiting for key release
  // RELEASE  | key released, counting stable-low cycles
  // LOCKED   | timer running, entry ignored

  logic [2:0] state, state_nxt;
  digits_t    digits;
  logic       start_q;

  logic key_valid, start_edge, all_zero;
  logic stable, terminal;
  logic cnt_clear, cnt_count, cap;
  logic accept, zero_digits, load_nxt, err_nxt;

  // Out-of-range codes are treated as no key at all.
  assign key_valid  = valid && is_digit(bcd);
  assign start_edge = start_key && !start_q;
  assign all_zero   = (digits == '0);

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .count    (cnt_count),
    .capture  (cap),
    .code     (bcd),
    .key_valid(key_valid),
    .stable   (stable),
    .terminal (terminal)
  );

  always_comb begin
    state_nxt   = state;
    cnt_clear   = 1'b0;
    cnt_count   = 1'b0;
    cap         = 1'b0;
    accept      = 1'b0;
    zero_digits = 1'b0;
    load_nxt    = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_edge && !all_zero && digits.sec_tens > MAX_SEC_TENS) begin
          err_nxt = 1'b1;
        end else if (start_edge && !all_zero) begin
          load_nxt  = 1'b1;
          state_nxt = ST_LOCKED;
        end else if (key_valid) begin
          state_nxt = ST_DEBOUNCE;
          cap       = 1'b1;
          cnt_clear = 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!stable) begin
          state_nxt = ST_IDLE;
        end else if (terminal) begin
          accept    = 1'b1;
          state_nxt = ST_HELD;
        end else begin
          cnt_count = 1'b1;
        end
      end
      ST_HELD: begin
        if (!key_valid) begin
          state_nxt = ST_RELEASE;
          cnt_clear = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (key_valid)
          state_nxt = ST_HELD;
        else if (terminal)
          state_nxt = ST_IDLE;
        else
          cnt_count = 1'b1;
      end
      ST_LOCKED: begin
        cnt_clear = 1'b1;
        if (!timer_busy) begin
          state_nxt   = ST_IDLE;
          zero_digits = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Clear overrides any acceptance or start; a busy timer overrides everything.
    if (state != ST_LOCKED) begin
      if (clear_key) begin
        zero_digits = 1'b1;
        accept      = 1'b0;
        load_nxt    = 1'b0;
        err_nxt     = 1'b0;
        state_nxt   = ST_IDLE;
      end
      if (timer_busy) begin
        accept    = 1'b0;
        load_nxt  = 1'b0;
        err_nxt   = 1'b0;
        state_nxt = ST_LOCKED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      digits    <= '0;
      start_q   <= 1'b0;
      load      <= 1'b0;
      entry_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      start_q   <= start_key;
      load      <= load_nxt;
      entry_err <= err_nxt;
      if (zero_digits)
        digits <= '0;
      else if (accept)
        digits <= shift_in(digits, bcd);
    end
  end

  assign enc_nenable = (state == ST_LOCKED);
  assign min_tens    = digits.min_tens;
  assign min_ones    = digits.min_ones;
  assign sec_tens    = digits.sec_tens;
  assign sec_ones    = digits.sec_ones;

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept or release a key (range 1..255).
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: valid  input  1  encoder Valid (a digit key is pressed).
REQ-005 Port: bcd  input  4  encoder BCD code of the pressed key (0..9).
REQ-006 Port: clear_key  input  1  clear-entry key, level, active-high.
REQ-007 Port: start_key  input  1  start key, level, active-high.
REQ-008 Port: timer_busy  input  1  downstream timer is counting; entry locked.
REQ-009 Port: enc_nenable  output  1  encoder enable, active-low.
REQ-010 Port: min_tens, min_ones, sec_tens, sec_ones  output  4 each  entered time digits, BCD.
REQ-011 Port: load  output  1  one-cycle pulse; timer loads the digit outputs.
REQ-012 Port: entry_err  output  1  one-cycle pulse; start rejected.

Function
REQ-013 FSM states: IDLE, DEBOUNCE, HELD, RELEASE, LOCKED.
REQ-014 enc_nenable SHALL be 0 in IDLE, DEBOUNCE, HELD and RELEASE, and 1 in LOCKED.
REQ-015 IDLE: valid=1 -> DEBOUNCE; capture bcd; clear the debounce counter.
REQ-016 DEBOUNCE: counter increments while valid=1 and bcd equals the captured value; valid=0 or a bcd change -> IDLE with no digit accepted.
REQ-017 DEBOUNCE: when the counter reaches DEBOUNCE_CYCLES-1 with a stable input -> HELD, and the captured digit is accepted in that same transition cycle.
REQ-018 Digit acceptance SHALL shift the digits: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit; the old min_tens is discarded.
REQ-019 HELD: valid=0 -> RELEASE with the counter cleared; no further digits are accepted while a key is held.
REQ-020 RELEASE: valid must stay 0 for DEBOUNCE_CYCLES cycles before -> IDLE; valid=1 during this wait -> HELD.
REQ-021 clear_key=1 in any non-LOCKED state SHALL zero all four digits and force IDLE next cycle.
REQ-022 clear_key has priority over a simultaneous digit acceptance and over start_key.
REQ-023 start_key is sampled only in IDLE; its rising edge is detected against a registered copy.
REQ-024 On a start edge with sec_tens<=5 and at least one digit non-zero: assert load for one cycle -> LOCKED.
REQ-025 On a start edge with sec_tens>5: pulse entry_err for one cycle; stay in IDLE; digits unchanged.
REQ-026 On a start edge with all digits zero: do nothing (no load, no entry_err).
REQ-027 LOCKED: ignore valid, clear_key and start_key; on timer_busy=0 -> IDLE and zero the digits.
REQ-028 timer_busy=1 while in any state other than LOCKED SHALL force LOCKED next cycle; an in-progress digit is discarded.
REQ-029 Digit outputs SHALL be registered and remain stable except on accept, clear or unlock.
REQ-030 bcd values 10..15 while valid=1 SHALL be treated as valid=0.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, all digits 0, load=0, entry_err=0, enc_nenable=0, counter 0, start edge register 0.
REQ-032 rst asserted mid-debounce or during LOCKED SHALL discard all pending state; after release the block resumes from IDLE.

Structure
REQ-033 FSM state encodings and the MAX_SEC_TENS=5 constant SHALL reside in the shared microwave definitions include file.
REQ-034 One sub-module is permitted: key_debounce, holding the counter and the stable/changed comparison; the FSM and digit register stay in keypad_entry_ctrl.

Verification
REQ-035 Press 1, 2, 3, 0 in turn (each held 6 cycles, then released 6 cycles) -> digits 1,2,3,0 (12:30); start -> one load pulse, enc_nenable=1.
REQ-036 valid glitches high for 2 cycles with DEBOUNCE_CYCLES=4 -> digits unchanged; FSM back in IDLE.
REQ-037 Key 7 held for 50 cycles -> exactly one shift; sec_ones=7.
REQ-038 Enter 0,0,7,5 then start -> entry_err pulse, no load, digits still 00:75; then clear_key -> all digits 0.
REQ-039 clear_key and digit acceptance in the same cycle -> digits 0; start with all zeros -> no load, no entry_err.
REQ-040 In LOCKED, press keys -> no change; timer_busy falls -> IDLE, digits 0, enc_nenable=0; rst pulse mid-DEBOUNCE -> all outputs at reset values.
